// File: rtl/hazard_scheduler.sv
// hazard_scheduler: hazard control for the five-stage ARM pipeline.
// Generates operand forwarding, load-use stalls, PC-write and branch flushes,
// and freezes the whole pipeline while data memory is not ready. A small
// wait-state FSM bounds memory waits (sticky MemTimeout on overrun) and a
// saturating counter tracks cycles in which fetch was stalled.
//
// Handshake note: the memory stage presents a request with MemReqM; the
// access completes in any cycle where MemReadyM is high. Once a wait has
// started (state MWAIT), only MemReadyM matters, as the request is held by
// the frozen memory-stage register.
module hazard_scheduler #(
    parameter int unsigned WAIT_LIMIT = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] A1D,
    input  logic [3:0] A2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       MemtoRegE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       PCSrcW,
    input  logic       BranchTakenE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MemTimeout,
    output logic [15:0] StallCycles,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [7:0] LP_LIMIT = 8'(WAIT_LIMIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_mem_timeout;
    logic [15:0] r_stall_cycles;

    logic        w_ld_stall;
    logic        w_pc_pend;
    logic        w_mem_stall;

    assign w_ld_stall  = MemtoRegE & ((A1D == WA3E) | (A2D == WA3E));
    assign w_pc_pend   = PCSrcD | PCSrcE | PCSrcM;
    assign MemTimeout  = r_mem_timeout;
    assign StallCycles = r_stall_cycles;
    assign o_dbg_state = r_state;

    // Operand forwarding into execute; memory stage result beats writeback.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (WA3M == RA1E) && (RA1E != 4'd15))
            ForwardAE = 2'b10;
        else if (RegWriteW && (WA3W == RA1E) && (RA1E != 4'd15))
            ForwardAE = 2'b01;
        if (RegWriteM && (WA3M == RA2E) && (RA2E != 4'd15))
            ForwardBE = 2'b10;
        else if (RegWriteW && (WA3W == RA2E) && (RA2E != 4'd15))
            ForwardBE = 2'b01;
        if (!RESET) begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end
    end

    // Wait-state FSM next state plus stall/flush outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_stall    = 1'b0;
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushW         = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_mem_stall = MemReqM & ~MemReadyM;
                if (w_mem_stall) begin
                    w_state_nxt    = ST_MWAIT;
                    w_wait_cnt_nxt = 8'd1;
                end else begin
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            ST_MWAIT: begin
                w_mem_stall = ~MemReadyM;
                if (MemReadyM) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt == LP_LIMIT) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase

        if (r_state == ST_FAULT) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (w_mem_stall) begin
            // Freeze everything; hazards re-evaluate once memory is ready.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = w_ld_stall | w_pc_pend;
            StallD = w_ld_stall;
            FlushD = w_pc_pend | PCSrcW | BranchTakenE;
            FlushE = w_ld_stall | BranchTakenE;
        end

        if (!RESET) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_mem_timeout <= r_mem_timeout | (w_state_nxt == ST_FAULT);
        end
    end

    // Saturating count of fetch-stalled cycles.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stall_cycles <= 16'd0;
        end else if (StallF && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed tests for hazard_scheduler (WAIT_LIMIT=4).
module tb_hazard_scheduler;

    logic       CLK;
    logic       RESET;
    logic [3:0] A1D, A2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       MemtoRegE, RegWriteM, RegWriteW;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic       BranchTakenE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic       MemTimeout;
    logic [15:0] StallCycles;
    logic [1:0] o_dbg_state;

    int n_checks;
    int n_fail;
    logic [15:0] exp_sc;

    hazard_scheduler #(.WAIT_LIMIT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .A1D(A1D), .A2D(A2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StallCycles(StallCycles),
        .o_dbg_state(o_dbg_state)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        A1D = 4'd0; A2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
        MemtoRegE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
        BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    // Step to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        clear_inputs();
        #3;
        n_checks++;
        if ({StallF, StallD, StallE, StallM} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_stalls: got %b want 0000", {StallF, StallD, StallE, StallM});
        end
        n_checks++;
        if ({FlushD, FlushE, FlushW} !== 3'b111) begin
            n_fail++; $display("FAIL reset_flushes: got %b want 111", {FlushD, FlushE, FlushW});
        end
        n_checks++;
        if ({MemTimeout, StallCycles, o_dbg_state} !== 19'd0) begin
            n_fail++; $display("FAIL reset_state: timeout=%b cycles=%h state=%0d want 0/0000/0",
                               MemTimeout, StallCycles, o_dbg_state);
        end
        next_cycle();
        RESET = 1'b1;
        exp_sc = 16'd0;
        #1;
        n_checks++;
        if ({StallF, FlushD, FlushE, FlushW} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_release_idle: got %b want 0000", {StallF, FlushD, FlushE, FlushW});
        end
    endtask

    task automatic test_forwarding();
        next_cycle();
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b10) begin
            n_fail++; $display("FAIL fwd_a_mem_priority: got %b want 10", ForwardAE);
        end
        RegWriteM = 1'b0;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_a_wb: got %b want 01", ForwardAE);
        end
        RA1E = 4'd15;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b00) begin
            n_fail++; $display("FAIL fwd_a_r15: got %b want 00", ForwardAE);
        end
        RA2E = 4'd7; WA3M = 4'd7; RegWriteM = 1'b1; WA3W = 4'd2;
        #1;
        n_checks++;
        if (ForwardBE !== 2'b10) begin
            n_fail++; $display("FAIL fwd_b_mem: got %b want 10", ForwardBE);
        end
        RA2E = 4'd2;
        #1;
        n_checks++;
        if (ForwardBE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_b_wb: got %b want 01", ForwardBE);
        end
        RegWriteW = 1'b0;
        #1;
        n_checks++;
        if (ForwardBE !== 2'b00) begin
            n_fail++; $display("FAIL fwd_b_none: got %b want 00", ForwardBE);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        next_cycle();
        MemtoRegE = 1'b1; WA3E = 4'd5; A2D = 4'd5; A1D = 4'd1;
        @(negedge CLK);
        n_checks++;
        if ({StallF, StallD, FlushE, FlushD, StallE} !== 5'b11100) begin
            n_fail++; $display("FAIL load_use_active: F/D/FE/FD/E got %b want 11100",
                               {StallF, StallD, FlushE, FlushD, StallE});
        end
        exp_sc = exp_sc + 16'd1;
        next_cycle();
        MemtoRegE = 1'b0;
        #1;
        n_checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b0000) begin
            n_fail++; $display("FAIL load_use_clear: got %b want 0000", {StallF, StallD, FlushE, FlushD});
        end
        n_checks++;
        if (StallCycles !== exp_sc) begin
            n_fail++; $display("FAIL load_use_count: got %h want %h", StallCycles, exp_sc);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        next_cycle();
        BranchTakenE = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
            n_fail++; $display("FAIL branch_flush: FD/FE/SF/SD got %b want 1100", {FlushD, FlushE, StallF, StallD});
        end
        next_cycle();
        BranchTakenE = 1'b0; PCSrcW = 1'b1;
        #1;
        n_checks++;
        if ({FlushD, FlushE, StallF} !== 3'b100) begin
            n_fail++; $display("FAIL pcsrcw_resume: FD/FE/SF got %b want 100", {FlushD, FlushE, StallF});
        end
        next_cycle();
        PCSrcW = 1'b0; PCSrcE = 1'b1;
        #1;
        n_checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1010) begin
            n_fail++; $display("FAIL pc_pending: SF/SD/FD/FE got %b want 1010", {StallF, StallD, FlushD, FlushE});
        end
        exp_sc = exp_sc + 16'd1;
        next_cycle();
        clear_inputs();
        #1;
        n_checks++;
        if (StallCycles !== exp_sc) begin
            n_fail++; $display("FAIL branch_count: got %h want %h", StallCycles, exp_sc);
        end
    endtask

    task automatic test_mem_wait();
        next_cycle();
        MemReqM = 1'b1; MemReadyM = 1'b1;
        #1;
        n_checks++;
        if ({StallF, StallM, FlushW} !== 3'b000) begin
            n_fail++; $display("FAIL mem_ready_same_cycle: got %b want 000", {StallF, StallM, FlushW});
        end
        next_cycle();
        MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b1111100) begin
                n_fail++; $display("FAIL mem_wait_cycle%0d: got %b want 1111100", i,
                                   {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE});
            end
            exp_sc = exp_sc + 16'd1;
            next_cycle();
        end
        MemReadyM = 1'b1;
        #1;
        n_checks++;
        if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b00000) begin
            n_fail++; $display("FAIL mem_wait_release: got %b want 00000",
                               {StallF, StallD, StallE, StallM, FlushW});
        end
        next_cycle();
        MemReqM = 1'b0;
        #1;
        n_checks++;
        if ({o_dbg_state, MemTimeout} !== 3'b000) begin
            n_fail++; $display("FAIL mem_wait_back_to_run: state=%0d timeout=%b want 0/0", o_dbg_state, MemTimeout);
        end
        n_checks++;
        if (StallCycles !== exp_sc) begin
            n_fail++; $display("FAIL mem_wait_count: got %h want %h", StallCycles, exp_sc);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic exp_to;
        next_cycle();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLK);
            exp_to = (i >= 6);
            n_checks++;
            if ({MemTimeout, StallF, StallD, StallE, StallM} !== {exp_to, 4'b1111}) begin
                n_fail++; $display("FAIL timeout_cycle%0d: to/stalls got %b want %b", i,
                                   {MemTimeout, StallF, StallD, StallE, StallM}, {exp_to, 4'b1111});
            end
            if (i == 6) begin
                n_checks++;
                if ({o_dbg_state, FlushW, FlushD, FlushE} !== 5'b10000) begin
                    n_fail++; $display("FAIL fault_outputs: state/FW/FD/FE got %b want 10000",
                                       {o_dbg_state, FlushW, FlushD, FlushE});
                end
                MemReadyM = 1'b1; MemReqM = 1'b0; BranchTakenE = 1'b1;
            end
            @(posedge CLK);
        end
        #3;
        RESET = 1'b0;
        #1;
        n_checks++;
        if ({MemTimeout, StallCycles, o_dbg_state} !== 19'd0) begin
            n_fail++; $display("FAIL async_reset_clear: timeout=%b cycles=%h state=%0d want 0/0000/0",
                               MemTimeout, StallCycles, o_dbg_state);
        end
        clear_inputs();
        @(negedge CLK);
        RESET = 1'b1;
        exp_sc = 16'd0;
    endtask

    task automatic test_saturation();
        next_cycle();
        PCSrcD = 1'b1;
        repeat (65534) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (StallCycles !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_pre: got %h want fffe", StallCycles);
        end
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (StallCycles !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h want ffff", StallCycles);
        end
        next_cycle();
        PCSrcD = 1'b0; MemReqM = 1'b1; MemReadyM = 1'b0; BranchTakenE = 1'b1;
        MemtoRegE = 1'b1; WA3E = 4'd5; A1D = 4'd5;
        #1;
        n_checks++;
        if ({FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW} !== 7'b0011111) begin
            n_fail++; $display("FAIL memstall_priority: got %b want 0011111",
                               {FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW});
        end
        next_cycle();
        MemReadyM = 1'b1;
        #1;
        n_checks++;
        if ({FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW} !== 7'b1111000) begin
            n_fail++; $display("FAIL deferred_hazards: got %b want 1111000",
                               {FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW});
        end
        next_cycle();
        clear_inputs();
        #1;
        n_checks++;
        if (StallCycles !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_after: got %h want ffff", StallCycles);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_sc   = 16'd0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
